// File: rtl/icu.sv
// icu: 1-bit MC14500B-style control unit executing one 4-bit instruction per clock.
// Optional macro ICU_SKIP_EN enables the RTN/SKZ skip-next-instruction logic.
package instructions;
  typedef enum logic [3:0] {
    NOPO, LD, LDC, AND, ANDC, OR, ORC, XNOR,
    STO, STOC, IEN, OEN, JMP, RTN, SKZ, NOPF
  } instruction_t;
endpackage

module icu
  import instructions::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         data_in,
  input  instruction_t i,
  output logic         write,
  output logic         data_out,
  output logic         jmp,
  output logic         rtn,
  output logic         flag_o,
  output logic         flag_f,
  output logic         rr_out
);
  logic rr, ien_register, oen_register, din, exec;
  logic rr_n, ien_n, oen_n, data_n, write_n, jmp_n, rtn_n, fo_n, ff_n;
`ifdef ICU_SKIP_EN
  logic skip, skip_n;
  assign exec = ~skip;
`else
  assign exec = 1'b1;
`endif
  assign din = data_in & ien_register;
  assign rr_out = rr;
  always_comb begin
    rr_n = rr;
    ien_n = ien_register;
    oen_n = oen_register;
    data_n = data_out;
    write_n = 1'b0;
    jmp_n = 1'b0;
    rtn_n = 1'b0;
    fo_n = 1'b0;
    ff_n = 1'b0;
`ifdef ICU_SKIP_EN
    skip_n = 1'b0;
`endif
    if (exec) begin
      case (i)
        NOPO: fo_n = 1'b1;
        LD:   rr_n = din;
        LDC:  rr_n = ~din;
        AND:  rr_n = rr & din;
        ANDC: rr_n = rr & ~din;
        OR:   rr_n = rr | din;
        ORC:  rr_n = rr | ~din;
        XNOR: rr_n = ~(rr ^ din);
        STO:  begin data_n = oen_register ? rr : data_out; write_n = oen_register; end
        STOC: begin data_n = oen_register ? ~rr : data_out; write_n = oen_register; end
        IEN:  ien_n = data_in;
        OEN:  oen_n = data_in;
        JMP:  jmp_n = 1'b1;
        RTN: begin
          rtn_n = 1'b1;
`ifdef ICU_SKIP_EN
          skip_n = 1'b1;
`endif
        end
        SKZ: begin
`ifdef ICU_SKIP_EN
          skip_n = ~rr;
`endif
        end
        NOPF: ff_n = 1'b1;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr <= 1'b0;
      ien_register <= 1'b0;
      oen_register <= 1'b0;
      data_out <= 1'b0;
      write <= 1'b0;
      jmp <= 1'b0;
      rtn <= 1'b0;
      flag_o <= 1'b0;
      flag_f <= 1'b0;
`ifdef ICU_SKIP_EN
      skip <= 1'b0;
`endif
    end else begin
      rr <= rr_n;
      ien_register <= ien_n;
      oen_register <= oen_n;
      data_out <= data_n;
      write <= write_n;
      jmp <= jmp_n;
      rtn <= rtn_n;
      flag_o <= fo_n;
      flag_f <= ff_n;
`ifdef ICU_SKIP_EN
      skip <= skip_n;
`endif
    end
  end
endmodule

// File: tb/tb_icu.sv
// tb_icu: scoreboard bench for icu; directed program followed by random instructions.
module tb_icu;
  import instructions::*;
  logic clk = 1'b0, rst = 1'b0, data_in = 1'b0;
  instruction_t i = NOPO;
  logic write, data_out, jmp, rtn, flag_o, flag_f, rr_out;
  int checks = 0, failures = 0;
  typedef struct { logic [8:0] v; int op; } exp_t;
  exp_t q[$];
  logic m_rr, m_ien, m_oen, m_dout, m_skip;

  icu dut (.clk(clk), .rst(rst), .data_in(data_in), .i(i), .write(write),
           .data_out(data_out), .jmp(jmp), .rtn(rtn), .flag_o(flag_o),
           .flag_f(flag_f), .rr_out(rr_out));

  always #5 clk = ~clk;

  function automatic logic [8:0] observed();
    return {write, data_out, jmp, rtn, flag_o, flag_f, rr_out,
            dut.ien_register, dut.oen_register};
  endfunction

  task automatic model_reset();
    m_rr = 0; m_ien = 0; m_oen = 0; m_dout = 0; m_skip = 0;
  endtask

  // Reference: each opcode's effect on the architectural bits, flags as one-cycle outputs.
  task automatic do_op(input int op, input logic d);
    logic g, w, j, r, fo, ff, ns;
    exp_t e;
    @(negedge clk);
    i = instruction_t'(op);
    data_in = d;
    g = d && m_ien;
    {w, j, r, fo, ff, ns} = '0;
    if (!m_skip) begin
      if (op == 0) fo = 1;
      if (op == 1) m_rr = g;
      if (op == 2) m_rr = !g;
      if (op == 3) m_rr = m_rr && g;
      if (op == 4) m_rr = m_rr && !g;
      if (op == 5) m_rr = m_rr || g;
      if (op == 6) m_rr = m_rr || !g;
      if (op == 7) m_rr = (m_rr == g);
      if ((op == 8 || op == 9) && m_oen) begin
        m_dout = (op == 8) ? m_rr : !m_rr;
        w = 1;
      end
      if (op == 10) m_ien = d;
      if (op == 11) m_oen = d;
      if (op == 12) j = 1;
      if (op == 13) r = 1;
      if (op == 15) ff = 1;
`ifdef ICU_SKIP_EN
      if (op == 13) ns = 1;
      if (op == 14) ns = (m_rr == 0);
`endif
    end
    m_skip = ns;
    e.v = {w, m_dout, j, r, fo, ff, m_rr, m_ien, m_oen};
    e.op = op;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic [8:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = observed();
        checks++;
        if (a !== e.v) begin
          failures++;
          $display("FAIL op%0d {wr,dout,jmp,rtn,fo,ff,rr,ien,oen} got=%b exp=%b", e.op, a, e.v);
        end
      end
    end
  end

  initial begin
    int n;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (observed() !== 9'b0) begin
      failures++;
      $display("FAIL reset got=%b exp=%b", observed(), 9'b0);
    end
    @(negedge clk);
    rst = 1;
    do_op(10, 0); do_op(10, 1); do_op(11, 0); do_op(11, 1);
    do_op(1, 1); do_op(2, 0); do_op(5, 0); do_op(5, 1); do_op(8, 0);
    do_op(3, 1); do_op(3, 0); do_op(8, 1);
    do_op(0, 0); do_op(15, 0); do_op(1, 1);
    do_op(9, 0); do_op(7, 1); do_op(4, 1); do_op(6, 1); do_op(12, 0);
    do_op(10, 0); do_op(1, 1); do_op(11, 0); do_op(1, 0); do_op(2, 1); do_op(8, 0);
    do_op(10, 1); do_op(11, 1);
    do_op(1, 0); do_op(14, 0); do_op(1, 1); do_op(1, 1);
    do_op(13, 0); do_op(1, 0); do_op(2, 0);
    do_op(1, 0); do_op(14, 0); do_op(14, 0); do_op(15, 0);
    for (int k = 0; k < 400; k++) begin
      if (k == 200) begin
        @(negedge clk);
        #2 rst = 0;
        #1;
        checks++;
        if (observed() !== 9'b0) begin
          failures++;
          $display("FAIL async_reset got=%b exp=%b", observed(), 9'b0);
        end
        model_reset();
        @(negedge clk);
        rst = 1;
      end
      do_op(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
